keypad_time_entry: RTL and testbench

- Downstream consumer of the keypad stage: takes the 4-digit BCD shift register (`keypad_values`) and its `shift_pulse`.
- Counts digit entries and validates the entry as HH:MM on a set command.
- Presents validated BCD hours/minutes with a one-cycle load strobe to the time or alarm register.
- Drives `reset_shift` back to the keypad to blank the display after every commit, abort or timeout.

---
 rtl/keypad_time_entry.sv | 187 ++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// Collects keypad digit entries, validates them as HH:MM on a set command and
// emits a one-cycle load strobe for the clock or alarm register.
module keypad_time_entry #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter int unsigned HOUR_MODE_24   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        set_time_btn,
  input  logic        set_alarm_btn,
  input  logic        clear_btn,
  output logic [7:0]  set_hours,
  output logic [7:0]  set_minutes,
  output logic        time_load,
  output logic        alarm_load,
  output logic        reset_shift,
  output logic        entry_error,
  output logic [2:0]  digit_count,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;
  localparam logic [2:0] S_ABORT   = 3'd5;

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

  // Bit order of the synchronized inputs: {clear, alarm, time, digit}
  logic [3:0]                    async_in;
  logic [SYNC_STAGES-1:0][3:0]   sync_reg;
  logic [3:0]                    sync_out;
  logic [3:0]                    prev_reg;
  logic [3:0]                    rise;

  assign async_in = {clear_btn, set_alarm_btn, set_time_btn, shift_pulse};
  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_out;
    end
  end

  logic digit_rise, time_rise, alarm_rise, clear_rise;
  assign digit_rise = rise[0];
  assign time_rise  = rise[1];
  assign alarm_rise = rise[2];
  assign clear_rise = rise[3];

  logic [2:0]  state_reg, state_next;
  logic [2:0]  digit_count_reg, digit_count_next;
  logic [23:0] timeout_reg, timeout_next;
  logic        target_alarm_reg, target_alarm_next;
  logic [7:0]  set_hours_reg, set_minutes_reg;
  logic        time_load_reg, alarm_load_reg, reset_shift_reg, entry_error_reg;
  logic        do_commit, do_reset_shift, err_set, err_clr;

  // Entry validation on the live keypad register
  logic [3:0] h_tens, h_ones, m_tens, m_ones;
  logic       all_bcd, min_ok, hour_ok_24, hour_ok_12, hour_ok, entry_valid;

  assign h_tens = keypad_values[15:12];
  assign h_ones = keypad_values[11:8];
  assign m_tens = keypad_values[7:4];
  assign m_ones = keypad_values[3:0];

  assign all_bcd    = (h_tens <= 4'd9) && (h_ones <= 4'd9) &&
                      (m_tens <= 4'd9) && (m_ones <= 4'd9);
  assign min_ok     = (m_tens <= 4'd5);
  assign hour_ok_24 = (h_tens < 4'd2) || ((h_tens == 4'd2) && (h_ones <= 4'd3));
  assign hour_ok_12 = ((h_tens == 4'd0) && (h_ones != 4'd0)) ||
                      ((h_tens == 4'd1) && (h_ones <= 4'd2));
  assign hour_ok     = (HOUR_MODE_24 != 0) ? hour_ok_24 : hour_ok_12;
  assign entry_valid = (digit_count_reg == 3'd4) && all_bcd && min_ok && hour_ok;

  always_comb begin
    state_next        = state_reg;
    digit_count_next  = digit_count_reg;
    timeout_next      = timeout_reg;
    target_alarm_next = target_alarm_reg;
    do_commit         = 1'b0;
    do_reset_shift    = 1'b0;
    err_set           = 1'b0;
    err_clr           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (clear_rise) begin
          do_reset_shift = 1'b1;
        end else if (time_rise || alarm_rise) begin
          state_next = S_ERROR;
        end else if (digit_rise) begin
          digit_count_next = 3'd1;
          err_clr          = 1'b1;
          state_next       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (clear_rise) begin
          state_next = S_ABORT;
        end else if (time_rise && alarm_rise) begin
          state_next = S_ERROR;
        end else if (time_rise || alarm_rise) begin
          target_alarm_next = alarm_rise;
          state_next        = S_CHECK;
        end else if (digit_rise) begin
          if (digit_count_reg != 3'd4) begin
            digit_count_next = digit_count_reg + 3'd1;
          end
          timeout_next = '0;
        end else if (timeout_reg == TIMEOUT_LAST) begin
          state_next = S_ABORT;
        end else begin
          timeout_next = timeout_reg + 24'd1;
        end
      end
      S_CHECK:  state_next = entry_valid ? S_COMMIT : S_ERROR;
      S_COMMIT: state_next = S_IDLE;
      S_ERROR:  state_next = S_IDLE;
      S_ABORT:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Side effects are registered on entry so they line up with the one-cycle
    // COMMIT / ERROR / ABORT state.
    if ((state_next == S_COMMIT) || (state_next == S_ERROR) || (state_next == S_ABORT)) begin
      digit_count_next = 3'd0;
      do_reset_shift   = 1'b1;
    end
    if (state_next == S_ERROR)  err_set   = 1'b1;
    if (state_next == S_COMMIT) do_commit = 1'b1;
    if (state_next != S_COLLECT) timeout_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      digit_count_reg  <= 3'd0;
      timeout_reg      <= '0;
      target_alarm_reg <= 1'b0;
      set_hours_reg    <= 8'h00;
      set_minutes_reg  <= 8'h00;
      time_load_reg    <= 1'b0;
      alarm_load_reg   <= 1'b0;
      reset_shift_reg  <= 1'b0;
      entry_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      digit_count_reg  <= digit_count_next;
      timeout_reg      <= timeout_next;
      target_alarm_reg <= target_alarm_next;
      time_load_reg    <= do_commit & ~target_alarm_reg;
      alarm_load_reg   <= do_commit & target_alarm_reg;
      reset_shift_reg  <= do_reset_shift;
      if (do_commit) begin
        set_hours_reg   <= keypad_values[15:8];
        set_minutes_reg <= keypad_values[7:0];
      end
      if (err_set) begin
        entry_error_reg <= 1'b1;
      end else if (err_clr) begin
        entry_error_reg <= 1'b0;
      end
    end
  end

  assign set_hours   = set_hours_reg;
  assign set_minutes = set_minutes_reg;
  assign time_load   = time_load_reg;
  assign alarm_load  = alarm_load_reg;
  assign reset_shift = reset_shift_reg;
  assign entry_error = entry_error_reg;
  assign digit_count = digit_count_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: a 24h and a 12h instance share stimulus and are
// checked against a transaction-level HH:MM model.
module tb_keypad_time_entry;

  localparam int SYNC = 2;
  localparam int TO   = 16;

  localparam int CMD_TIME = 0, CMD_ALARM = 1, CMD_CLEAR = 2, CMD_BOTH = 3, CMD_CLEAR_TIME = 4;
  localparam int OUT_NONE = 0, OUT_TIME = 1, OUT_ALARM = 2, OUT_ERR = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keypad_values;
  logic        shift_pulse, set_time_btn, set_alarm_btn, clear_btn;

  logic [7:0] hours_o [2];
  logic [7:0] mins_o  [2];
  logic       tl_o    [2];
  logic       al_o    [2];
  logic       rs_o    [2];
  logic       err_o   [2];
  logic [2:0] cnt_o   [2];
  logic       busy_o  [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] model_h   [2];
  logic [7:0] model_m   [2];
  bit         model_err [2];

  always #5 clk = ~clk;

  keypad_time_entry #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(24'd16), .HOUR_MODE_24(1)) dut24 (
    .clk(clk), .reset_n(reset_n), .keypad_values(keypad_values), .shift_pulse(shift_pulse),
    .set_time_btn(set_time_btn), .set_alarm_btn(set_alarm_btn), .clear_btn(clear_btn),
    .set_hours(hours_o[0]), .set_minutes(mins_o[0]), .time_load(tl_o[0]), .alarm_load(al_o[0]),
    .reset_shift(rs_o[0]), .entry_error(err_o[0]), .digit_count(cnt_o[0]), .busy(busy_o[0]));

  keypad_time_entry #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(24'd16), .HOUR_MODE_24(0)) dut12 (
    .clk(clk), .reset_n(reset_n), .keypad_values(keypad_values), .shift_pulse(shift_pulse),
    .set_time_btn(set_time_btn), .set_alarm_btn(set_alarm_btn), .clear_btn(clear_btn),
    .set_hours(hours_o[1]), .set_minutes(mins_o[1]), .time_load(tl_o[1]), .alarm_load(al_o[1]),
    .reset_shift(rs_o[1]), .entry_error(err_o[1]), .digit_count(cnt_o[1]), .busy(busy_o[1]));

  typedef struct {
    int          ndig;
    logic [15:0] kv;
    int          cmd;
    int          exp24;
    int          exp12;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  function automatic bit valid_hhmm(input logic [15:0] kv, input bit mode24);
    int ht, ho, mt, mo, hrs, mins;
    ht = int'(kv[15:12]); ho = int'(kv[11:8]);
    mt = int'(kv[7:4]);   mo = int'(kv[3:0]);
    if (ht > 9 || ho > 9 || mt > 9 || mo > 9) return 1'b0;
    hrs  = ht * 10 + ho;
    mins = mt * 10 + mo;
    if (mins >= 60) return 1'b0;
    if (mode24) return hrs <= 23;
    return (hrs >= 1) && (hrs <= 12);
  endfunction

  function automatic int expect_outcome(input int ndig, input logic [15:0] kv,
                                        input int cmd, input bit mode24);
    if (cmd == CMD_CLEAR || cmd == CMD_CLEAR_TIME) return OUT_NONE;
    if (cmd == CMD_BOTH || ndig == 0) return OUT_ERR;
    if (ndig >= 4 && valid_hhmm(kv, mode24)) return (cmd == CMD_TIME) ? OUT_TIME : OUT_ALARM;
    return OUT_ERR;
  endfunction

  task automatic press_digit();
    @(negedge clk);
    shift_pulse = 1'b1;
    repeat (2) @(posedge clk);
    #1 shift_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int ndig, input logic [15:0] kv, input int cmd,
                         input int exp0, input int exp1);
    int exp_out [2];
    int tl_n [2], al_n [2], rs_n [2], both_n [2], first_k [2];
    exp_out[0] = exp0;
    exp_out[1] = exp1;
    keypad_values = kv;
    for (int i = 0; i < ndig; i++) press_digit();
    if (ndig > 0) begin
      for (int d = 0; d < 2; d++) begin
        check("digit_count_collect", d, cnt_o[d], (ndig > 4) ? 4 : ndig);
        check("busy_collect", d, busy_o[d], 1);
        check("error_cleared_by_digit", d, err_o[d], 0);
        model_err[d] = 1'b0;
      end
    end
    @(negedge clk);
    case (cmd)
      CMD_TIME:       set_time_btn = 1'b1;
      CMD_ALARM:      set_alarm_btn = 1'b1;
      CMD_CLEAR:      clear_btn = 1'b1;
      CMD_BOTH:       begin set_time_btn = 1'b1; set_alarm_btn = 1'b1; end
      default:        begin set_time_btn = 1'b1; clear_btn = 1'b1; end
    endcase
    for (int d = 0; d < 2; d++) begin
      tl_n[d] = 0; al_n[d] = 0; rs_n[d] = 0; both_n[d] = 0; first_k[d] = 0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        set_time_btn = 1'b0; set_alarm_btn = 1'b0; clear_btn = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        if (tl_o[d]) tl_n[d]++;
        if (al_o[d]) al_n[d]++;
        if (rs_o[d]) rs_n[d]++;
        if (tl_o[d] && al_o[d]) both_n[d]++;
        if ((tl_o[d] || al_o[d]) && first_k[d] == 0) first_k[d] = k;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (exp_out[d] == OUT_TIME || exp_out[d] == OUT_ALARM) begin
        model_h[d] = kv[15:8];
        model_m[d] = kv[7:0];
        check("load_latency", d, first_k[d], SYNC + 2);
      end
      if (exp_out[d] == OUT_ERR) model_err[d] = 1'b1;
      check("time_load_count", d, tl_n[d], (exp_out[d] == OUT_TIME) ? 1 : 0);
      check("alarm_load_count", d, al_n[d], (exp_out[d] == OUT_ALARM) ? 1 : 0);
      check("loads_together", d, both_n[d], 0);
      check("reset_shift_count", d, rs_n[d], 1);
      check("set_hours", d, hours_o[d], model_h[d]);
      check("set_minutes", d, mins_o[d], model_m[d]);
      check("entry_error", d, err_o[d], model_err[d]);
      check("digit_count_after", d, cnt_o[d], 0);
      check("busy_after", d, busy_o[d], 0);
    end
    $display("txn digits=%0d kv=%04h cmd=%0d exp24=%0d exp12=%0d", ndig, kv, cmd, exp0, exp1);
  endtask

  initial begin
    int strobes [2];
    int rs_k [2];
    int ndig, cmd;
    logic [15:0] kv;

    reset_n = 1'b0;
    keypad_values = 16'hAAAA;
    shift_pulse = 1'b0; set_time_btn = 1'b0; set_alarm_btn = 1'b0; clear_btn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_h[d] = 8'h00; model_m[d] = 8'h00; model_err[d] = 1'b0; strobes[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Idle after reset: nothing moves
    repeat (100) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        if (tl_o[d] || al_o[d] || rs_o[d] || busy_o[d]) strobes[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      check("idle_activity", d, strobes[d], 0);
      check("reset_hours", d, hours_o[d], 0);
      check("reset_minutes", d, mins_o[d], 0);
      check("reset_error", d, err_o[d], 0);
      check("reset_count", d, cnt_o[d], 0);
    end

    vecs[0]  = '{4, 16'h0745, CMD_ALARM,      OUT_ALARM, OUT_ALARM};
    vecs[1]  = '{4, 16'h2460, CMD_TIME,       OUT_ERR,   OUT_ERR};
    vecs[2]  = '{4, 16'h12A5, CMD_TIME,       OUT_ERR,   OUT_ERR};
    vecs[3]  = '{3, 16'h0930, CMD_TIME,       OUT_ERR,   OUT_ERR};
    vecs[4]  = '{4, 16'h1230, CMD_TIME,       OUT_TIME,  OUT_TIME};
    vecs[5]  = '{4, 16'h0030, CMD_TIME,       OUT_TIME,  OUT_ERR};
    vecs[6]  = '{2, 16'h1111, CMD_CLEAR_TIME, OUT_NONE,  OUT_NONE};
    vecs[7]  = '{0, 16'h0000, CMD_CLEAR,      OUT_NONE,  OUT_NONE};
    vecs[8]  = '{0, 16'h1234, CMD_TIME,       OUT_ERR,   OUT_ERR};
    vecs[9]  = '{5, 16'h2359, CMD_TIME,       OUT_TIME,  OUT_ERR};
    vecs[10] = '{4, 16'h1960, CMD_ALARM,      OUT_ERR,   OUT_ERR};
    vecs[11] = '{2, 16'h1200, CMD_BOTH,       OUT_ERR,   OUT_ERR};
    vecs[12] = '{4, 16'h0000, CMD_TIME,       OUT_TIME,  OUT_ERR};
    vecs[13] = '{4, 16'h1300, CMD_ALARM,      OUT_ALARM, OUT_ERR};
    for (int i = 0; i < 14; i++)
      run_txn(vecs[i].ndig, vecs[i].kv, vecs[i].cmd, vecs[i].exp24, vecs[i].exp12);

    // Two digits then silence: the entry must abort on timeout
    keypad_values = 16'h0100;
    press_digit();
    press_digit();
    for (int d = 0; d < 2; d++) begin
      rs_k[d] = 0; strobes[d] = 0; model_err[d] = 1'b0;
    end
    for (int k = 5; k <= 40; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (rs_o[d] && rs_k[d] == 0) rs_k[d] = k;
        if (tl_o[d] || al_o[d]) strobes[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check("timeout_abort_window", d,
            int'(rs_k[d] >= SYNC + TO && rs_k[d] <= SYNC + TO + 2), 1);
      check("timeout_no_load", d, strobes[d], 0);
      check("timeout_count", d, cnt_o[d], 0);
      check("timeout_busy", d, busy_o[d], 0);
      check("timeout_error", d, err_o[d], model_err[d]);
      check("timeout_hours", d, hours_o[d], model_h[d]);
    end
    $display("txn timeout after 2 digits");

    // Reset asserted while a valid entry sits in CHECK
    keypad_values = 16'h0930;
    repeat (4) press_digit();
    @(negedge clk) set_time_btn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 set_time_btn = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("busy_in_check", d, busy_o[d], 1);
      strobes[d] = 0;
    end
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (tl_o[d] || al_o[d] || rs_o[d]) strobes[d]++;
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) if (tl_o[d] || al_o[d] || rs_o[d]) strobes[d]++;
    end
    for (int d = 0; d < 2; d++) begin
      model_h[d] = 8'h00; model_m[d] = 8'h00; model_err[d] = 1'b0;
      check("midreset_strobes", d, strobes[d], 0);
      check("midreset_hours", d, hours_o[d], 0);
      check("midreset_minutes", d, mins_o[d], 0);
      check("midreset_count", d, cnt_o[d], 0);
      check("midreset_busy", d, busy_o[d], 0);
    end
    $display("txn reset during check");
    run_txn(4, 16'h0815, CMD_ALARM, OUT_ALARM, OUT_ALARM);

    // Randomized entries against the HH:MM model
    for (int t = 0; t < 40; t++) begin
      ndig = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 4;
      cmd  = int'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0) begin
        kv = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      end else begin
        kv = 16'($urandom());
      end
      run_txn(ndig, kv, cmd, expect_outcome(ndig, kv, cmd, 1'b1),
              expect_outcome(ndig, kv, cmd, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
